// File: rtl/ysyx_22050550_icache.sv
// ============================================================================
// ysyx_22050550_icache : direct-mapped read-only instruction cache, 16-byte
// lines refilled as a two-beat burst.  Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050550_icache #(
  parameter int SET_BITS = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Cache_valid,
  input  logic [63:0] Cache_addr,
  input  logic        Flush,
  output logic        Cache_DataOk,
  output logic [63:0] Cache_Data,
  output logic        Mem_valid,
  output logic [63:0] Mem_addr,
  input  logic        Mem_ready,
  input  logic        Mem_rvalid,
  input  logic [63:0] Mem_rdata,
  input  logic        Mem_rlast
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 60 - SET_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOOKUP   = 2'd1,
    S_MISS_REQ = 2'd2,
    S_REFILL   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [63:2]         addr_q, addr_d;
  logic                beat_q, beat_d;
  logic                inhibit_q, inhibit_d;
  logic [63:0]         buf_q, buf_d;
  logic                ok_q, ok_d;
  logic [63:0]         data_q, data_d;
  logic [SETS-1:0]     valid_q, valid_d;

  logic [TAG_W-1:0]    tag_mem   [SETS];
  logic [63:0]         line0_mem [SETS];
  logic [63:0]         line1_mem [SETS];

  logic [SET_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic [63:0]         w_fill0;
  logic                w_install;
  logic                w_unused;

  function automatic logic [63:0] pick(input logic [63:0] word, input logic hi);
    return {32'h0, hi ? word[63:32] : word[31:0]};
  endfunction

  assign w_idx   = addr_q[4+SET_BITS-1:4];
  assign w_tag   = addr_q[63:4+SET_BITS];
  assign w_hit   = valid_q[w_idx] && (tag_mem[w_idx] == w_tag);
  // rlast on beat 0 is a protocol error; word 0 then comes straight off the bus
  assign w_fill0 = beat_q ? buf_q : Mem_rdata;
  assign w_unused = ^Cache_addr[1:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    inhibit_d = inhibit_q;
    buf_d     = buf_q;
    ok_d      = 1'b0;
    data_d    = data_q;
    w_install = 1'b0;
    case (state_q)
      S_IDLE: begin
        inhibit_d = 1'b0;
        beat_d    = 1'b0;
        // the response cycle itself never accepts, so a lingering request cannot retrigger
        if (Cache_valid && !ok_q) begin
          addr_d  = Cache_addr[63:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit && !Flush) begin
          data_d  = pick(addr_q[3] ? line1_mem[w_idx] : line0_mem[w_idx], addr_q[2]);
          ok_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (Flush) inhibit_d = 1'b1;
        if (Mem_ready) state_d = S_REFILL;
      end
      S_REFILL: begin
        if (Flush) inhibit_d = 1'b1;
        if (Mem_rvalid) begin
          if (Mem_rlast) begin
            w_install = !(inhibit_q || Flush);
            data_d    = pick(addr_q[3] ? Mem_rdata : w_fill0, addr_q[2]);
            ok_d      = 1'b1;
            beat_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            buf_d  = Mem_rdata;
            beat_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (Flush) begin
      valid_d = '0;
    end else if (w_install) begin
      valid_d[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      beat_q    <= 1'b0;
      inhibit_q <= 1'b0;
      buf_q     <= '0;
      ok_q      <= 1'b0;
      data_q    <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      inhibit_q <= inhibit_d;
      buf_q     <= buf_d;
      ok_q      <= ok_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_install) begin
      tag_mem[w_idx]   <= w_tag;
      line0_mem[w_idx] <= w_fill0;
      line1_mem[w_idx] <= Mem_rdata;
    end
  end

  assign Cache_DataOk = ok_q;
  assign Cache_Data   = data_q;
  assign Mem_valid    = (state_q == S_MISS_REQ);
  assign Mem_addr     = {addr_q[63:4], 4'h0};

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050550_icache.sv
// ============================================================================
// tb_ysyx_22050550_icache : directed bench for the instruction cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050550_icache;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        Cache_valid = 1'b0;
  logic [63:0] Cache_addr = '0;
  logic        Flush = 1'b0;
  logic        Cache_DataOk;
  logic [63:0] Cache_Data;
  logic        Mem_valid;
  logic [63:0] Mem_addr;
  logic        Mem_ready = 1'b0;
  logic        Mem_rvalid = 1'b0;
  logic [63:0] Mem_rdata = '0;
  logic        Mem_rlast = 1'b0;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] W0 = 64'h00000013_00100093;
  localparam logic [63:0] W1 = 64'h00008067_00000513;

  ysyx_22050550_icache #(.SET_BITS(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .Cache_valid (Cache_valid),
    .Cache_addr  (Cache_addr),
    .Flush       (Flush),
    .Cache_DataOk(Cache_DataOk),
    .Cache_Data  (Cache_Data),
    .Mem_valid   (Mem_valid),
    .Mem_addr    (Mem_addr),
    .Mem_ready   (Mem_ready),
    .Mem_rvalid  (Mem_rvalid),
    .Mem_rdata   (Mem_rdata),
    .Mem_rlast   (Mem_rlast)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch; a miss is served with the given stall/gap timing.
  task automatic access(input logic [63:0] a, input bit miss,
                        input logic [63:0] w0, input logic [63:0] w1,
                        input int rdy_wait, input int gap,
                        input bit flush_mid, input bit hold,
                        input logic [63:0] exp);
    logic [63:0] line;
    line = {a[63:4], 4'h0};
    Cache_valid = 1'b1;
    Cache_addr  = a;
    step();
    chk("lookup_no_ok", Cache_DataOk, 0);
    chk("lookup_no_mem", Mem_valid, 0);
    step();
    if (!miss) begin
      chk("hit_no_mem", Mem_valid, 0);
    end else begin
      chk("miss_req", Mem_valid, 1);
      chk("miss_addr", Mem_addr, line);
      chk("miss_no_ok", Cache_DataOk, 0);
      for (int i = 0; i < rdy_wait; i++) begin
        step();
        chk("stall_valid", Mem_valid, 1);
        chk("stall_addr", Mem_addr, line);
      end
      Mem_ready = 1'b1;
      step();
      Mem_ready = 1'b0;
      chk("req_drop", Mem_valid, 0);
      for (int i = 0; i < gap; i++) step();
      Mem_rvalid = 1'b1; Mem_rdata = w0; Mem_rlast = 1'b0; Flush = flush_mid;
      step();
      Mem_rvalid = 1'b0; Flush = 1'b0;
      for (int i = 0; i < gap; i++) begin
        step();
        chk("gap_no_ok", Cache_DataOk, 0);
      end
      Mem_rvalid = 1'b1; Mem_rdata = w1; Mem_rlast = 1'b1;
      step();
      Mem_rvalid = 1'b0; Mem_rlast = 1'b0;
    end
    chk("resp_ok", Cache_DataOk, 1);
    chk("resp_data", Cache_Data, exp);
    if (!hold) Cache_valid = 1'b0;
    step();
    Cache_valid = 1'b0;
    chk("ok_pulse", Cache_DataOk, 0);
    chk("data_hold", Cache_Data, exp);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        step();
        chk("hold_no_ok", Cache_DataOk, 0);
        chk("hold_no_mem", Mem_valid, 0);
      end
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_ok", Cache_DataOk, 0);
    chk("rst_data", Cache_Data, 0);
    chk("rst_mvalid", Mem_valid, 0);
    chk("rst_maddr", Mem_addr, 0);
    reset = 1'b1;
    step();

    // cold miss, then hit on the other word of the same line
    access(64'h80000004, 1, W0, W1, 0, 0, 0, 0, 64'h00000000_00000013);
    access(64'h8000000C, 0, '0, '0, 0, 0, 0, 0, 64'h00000000_00008067);

    // conflict on set 0
    access(64'h80000400, 1, 64'h11111111_22222222, 64'h33333333_44444444,
           0, 0, 0, 0, 64'h00000000_22222222);
    access(64'h80000000, 1, W0, W1, 0, 0, 0, 0, 64'h00000000_00100093);
    access(64'h80000000, 0, '0, '0, 0, 0, 0, 0, 64'h00000000_00100093);

    // flush in IDLE
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    access(64'h80000000, 1, W0, W1, 0, 0, 0, 0, 64'h00000000_00100093);

    // flush during refill: data returned but line not installed
    access(64'h80000010, 1, 64'hAAAAAAAA_BBBBBBBB, 64'hCCCCCCCC_DDDDDDDD,
           0, 0, 1, 0, 64'h00000000_BBBBBBBB);
    access(64'h80000010, 1, 64'hAAAAAAAA_BBBBBBBB, 64'hCCCCCCCC_DDDDDDDD,
           0, 0, 0, 0, 64'h00000000_BBBBBBBB);

    // stalled memory with the request held through the response cycle
    access(64'h80000024, 1, 64'h12345678_9ABCDEF0, 64'h0F0F0F0F_F0F0F0F0,
           5, 3, 0, 1, 64'h00000000_12345678);

    // async reset after beat 0
    Cache_valid = 1'b1;
    Cache_addr  = 64'h80000030;
    step();
    step();
    chk("rr_req", Mem_valid, 1);
    Mem_ready = 1'b1;
    step();
    Mem_ready = 1'b0;
    Mem_rvalid = 1'b1; Mem_rdata = 64'h55555555_66666666;
    step();
    Mem_rvalid = 1'b0;
    Cache_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rr_ok", Cache_DataOk, 0);
    chk("rr_data", Cache_Data, 0);
    chk("rr_mvalid", Mem_valid, 0);
    chk("rr_maddr", Mem_addr, 0);
    step();
    reset = 1'b1;
    step();
    access(64'h80000030, 1, 64'h77777777_88888888, 64'h99999999_AAAAAAAA,
           0, 0, 0, 0, 64'h00000000_88888888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22050550_icache.md
# ysyx_22050550_icache

Direct-mapped, read-only instruction cache that answers the fetch unit's `Cache_valid`/`Cache_addr` request with a one-cycle `Cache_DataOk` pulse and the 32-bit instruction in `Cache_Data[31:0]`. It sits between the IFU and the memory bus. Misses are refilled as a two-beat line burst from a simple valid/ready read port.

## Interface
- `SET_BITS`, 6, log2 of set count (64 sets); line = 16 bytes = 2×64-bit words; tag = addr[63:4+SET_BITS]
- `clock`  input  1  sole clock, rising edge
- `reset`  input  1  asynchronous, active-low (0 = reset)
- `Cache_valid`  input  1  fetch request; requester holds it and `Cache_addr` stable until `Cache_DataOk`, and drops it in the `Cache_DataOk` cycle
- `Cache_addr`  input  64  fetch PC, 4-byte aligned
- `Flush`  input  1  invalidate all lines (fence.i), single-cycle pulse
- `Cache_DataOk`  output  1  registered response strobe, exactly one cycle
- `Cache_Data`  output  64  {32'h0, instruction}; valid only when `Cache_DataOk`=1
- `Mem_valid`  output  1  refill read request
- `Mem_addr`  output  64  line-aligned refill address ({addr[63:4], 4'h0})
- `Mem_ready`  input  1  request accepted when `Mem_valid & Mem_ready`
- `Mem_rvalid`  input  1  refill beat valid
- `Mem_rdata`  input  64  refill beat data, word 0 first
- `Mem_rlast`  input  1  marks beat 1

## Operation
- Storage: per set valid bit, tag, 2×64-bit data. Valid bits reset to 0; tag/data not reset.
- States: IDLE, LOOKUP, MISS_REQ, REFILL.
- IDLE: if `Cache_valid & !Cache_DataOk` → latch addr, go LOOKUP. Otherwise stay.
- LOOKUP: index = addr[4+SET_BITS-1:4]; hit = valid & tag match. Hit → load `Cache_Data`, set `Cache_DataOk`, go IDLE. Miss → go MISS_REQ.
- MISS_REQ: `Mem_valid`=1, `Mem_addr` line-aligned; hold until `Mem_ready`; then REFILL.
- REFILL: capture beat on each `Mem_rvalid` (beat counter 0→1). On the beat with `Mem_rlast`: write line, set valid, load `Cache_Data` from refilled data, set `Cache_DataOk`, go IDLE.
- Word select: 64-bit word = addr[3]; instruction = addr[2] ? word[63:32] : word[31:0].
- `Cache_DataOk` is asserted in the cycle the FSM is already back in IDLE. A request seen during that cycle is ignored, so a lingering `Cache_valid` cannot retrigger.
- Flush: clears all valid bits at the next edge in any state.
  - In LOOKUP, the flush takes priority: the access is treated as a miss.
  - During MISS_REQ/REFILL: the refill completes and returns data, but the line is not installed (install-inhibit flag, cleared on IDLE).
- `Mem_rvalid` outside REFILL is ignored. `Mem_rlast` on beat 0 is a protocol error; the line is still installed with beat 1 undefined (verification asserts this never occurs).

## Timing
- Reset values: `Cache_DataOk`=0, `Cache_Data`=0, `Mem_valid`=0, `Mem_addr`=0, state=IDLE, beat counter=0, install-inhibit=0, all valid bits=0. Async reset mid-refill aborts immediately and drops `Mem_valid`; the partial line is discarded.
- Hit: request seen in IDLE at edge t → LOOKUP in cycle t+1 → `Cache_DataOk` in cycle t+2 (2-cycle latency).
- Miss: t+1 LOOKUP, t+2 `Mem_valid` rises. Response comes one cycle after the `Mem_rlast` beat edge. Minimum latency with zero-wait memory: 5 cycles.
- Back-to-back: the next request is accepted at the edge after the `Cache_DataOk` cycle. Maximum throughput: 1 hit per 3 cycles.
- `Mem_valid`/`Mem_addr` are stable from assertion until the handshake edge.
- `Cache_Data` holds its value after `Cache_DataOk` falls, until the next load.

## Test plan
- Cold miss: reset, request 0x80000004; memory returns word0=0x00000013_00100093, word1=0x00008067_00000513 → `Mem_addr`=0x80000000, one `Cache_DataOk` with `Cache_Data`=0x00000000_00000013.
- Hit after fill: request 0x8000000C → no `Mem_valid`; `Cache_DataOk` 2 cycles after acceptance; `Cache_Data`=0x00000000_00008067.
- Conflict: with SET_BITS=6, request 0x80000400 (same index, new tag) → refill, then 0x80000000 misses again.
- Flush: pulse `Flush` in IDLE, then request 0x80000000 → miss. Pulse `Flush` mid-REFILL → data returned, but a repeat request misses.
- Stalled memory: `Mem_ready` low for 5 cycles and 3-cycle gap between beats → `Mem_valid`/`Mem_addr` held stable; exactly one `Cache_DataOk`. `Cache_valid` held high through the `Cache_DataOk` cycle does not start a second access.
- Reset mid-REFILL after beat 0 → all outputs at reset values within the same cycle; the following request to the same line misses.
